rom_decipher_sequencer: RTL

//  Sequences the 32-bit message ROM: reads the 3-word header (operation, key, stop char), then walks the cipher words.

---
 rtl/rom_decipher_sequencer_if.sv | 28 ++
 rtl/rom_decipher_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rom_decipher_sequencer_if.sv
// Purpose: bundles the ROM read port, deciphered character stream and status flags of the sequencer.
// Latency: none, wires only.
// Backpressure: out_valid/out_ready on the character stream; the ROM side has no flow control.
interface rom_decipher_sequencer_if #(
  parameter int ADDR_W = 11
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              error;

  // Sequencer side
  modport master (
    input  start, rom_data, out_ready,
    output rom_addr, out_data, out_valid, busy, done, error
  );

  // ROM plus character sink plus controller side
  modport slave (
    output start, rom_data, out_ready,
    input  rom_addr, out_data, out_valid, busy, done, error
  );
endinterface

// File: rtl/rom_decipher_sequencer.sv
// Purpose: reads the 3-word ROM header (op, key, stop char), then deciphers cipher words into a char stream.
// Latency: start -> first out_valid 5 cycles (9 with SYNC_ROM_EN, registered-read ROM); acceptance -> next char >= 2 (3).
// Backpressure: out_valid/out_data held stable in EMIT until out_ready; ROM address does not advance meanwhile.
module rom_decipher_sequencer #(
  parameter int                ADDR_W    = 11,
  parameter logic [ADDR_W-1:0] DATA_BASE = 11'h00C,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 11'h0FC
) (
  input logic                      clk,
  input logic                      rst,
  rom_decipher_sequencer_if.master bus
);

`ifdef SYNC_ROM_EN
  // Registered-read ROM: every read state spends one extra cycle with the address stable.
  localparam logic SYNC_RD = 1'b1;
`else
  localparam logic SYNC_RD = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] WORD_STRIDE = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] KEY_ADDR    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] STOP_ADDR   = ADDR_W'(8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_OP,
    S_HDR_KEY,
    S_HDR_STOP,
    S_FETCH,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [1:0]        op;
  logic [7:0]        key;
  logic [7:0]        stop;
  logic              rd_wait;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic              error;

  logic [7:0]        dec;
  logic              op_ok;

  // The whole op word must be 1, 2 or 3; stray upper bits make the header invalid.
  assign op_ok = (bus.rom_data != 32'd0) && (bus.rom_data[31:2] == 30'd0);

  // Decipher the low byte of the current ROM word with the latched op/key.
  always_comb begin
    dec = bus.rom_data[7:0];
    case (op)
      2'd1:    dec = bus.rom_data[7:0] ^ key;
      2'd2:    dec = ~bus.rom_data[7:0];
      2'd3:    dec = bus.rom_data[7:0] - key;
      default: dec = bus.rom_data[7:0];
    endcase
  end

  // Header parse, cipher walk and output handshake; all outputs registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rom_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      op        <= '0;
      key       <= '0;
      stop      <= '0;
      rd_wait   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            rom_addr <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b1;
            rd_wait  <= SYNC_RD;
            state    <= S_HDR_OP;
          end
        end
        S_HDR_OP: begin
          if (rd_wait) begin
            rd_wait <= 1'b0;
          end else begin
            op <= bus.rom_data[1:0];
            if (!op_ok) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_ERR;
            end else begin
              rom_addr <= KEY_ADDR;
              rd_wait  <= SYNC_RD;
              state    <= S_HDR_KEY;
            end
          end
        end
        S_HDR_KEY: begin
          if (rd_wait) begin
            rd_wait <= 1'b0;
          end else begin
            key      <= bus.rom_data[7:0];
            rom_addr <= STOP_ADDR;
            rd_wait  <= SYNC_RD;
            state    <= S_HDR_STOP;
          end
        end
        S_HDR_STOP: begin
          if (rd_wait) begin
            rd_wait <= 1'b0;
          end else begin
            stop     <= bus.rom_data[7:0];
            rom_addr <= DATA_BASE;
            rd_wait  <= SYNC_RD;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rd_wait) begin
            rd_wait <= 1'b0;
          end else if (dec == stop) begin
            // The stop char terminates the message and is never emitted.
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            out_data  <= dec;
            out_valid <= 1'b1;
            state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            if (rom_addr == LAST_ADDR) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_ERR;
            end else begin
              rom_addr <= rom_addr + WORD_STRIDE;
              rd_wait  <= SYNC_RD;
              state    <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr  = rom_addr;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.error     = error;

endmodule
